csa8_wide_add_seq: RTL and testbench

//   Multi-cycle sequencer that performs one NBYTES*8-bit addition on a single shared
//   8-bit carry-select adder, processing one byte per cycle, LSB byte first.
//   The carry-out of each byte slice is registered and fed back as the carry-in of the next.

---
 rtl/csa8_seq_pkg.sv | 24 ++
 rtl/carry_select_adder8.sv | 30 +++
 rtl/csa8_wide_add_seq.sv | 150 +++++++++++++++
 tb/tb_csa8_wide_add_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa8_seq_pkg.sv
// Shared types and constants for the byte-serial wide adder.
//   state_e : sequencer states (idle, run one byte per cycle, hold result)
//   BYTE_W  : width of one adder slice
//   clog2   : index width helper for the byte counter (minimum 1 bit)
package csa8_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/carry_select_adder8.sv
// 8-bit carry-select adder: the shared byte datapath of csa8_wide_add_seq.
// The low nibble ripples; the high nibble is computed for both possible
// carries and the low-nibble carry-out selects between them.
// Ports:
//   a, b  in  8  addends
//   cin   in  1  carry-in
//   sum   out 8  sum
//   cout  out 1  carry-out
module carry_select_adder8
  import csa8_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/csa8_wide_add_seq.sv
// Byte-serial NBYTES*8-bit adder built around one shared 8-bit carry-select
// adder. Operands are captured at accept, then one byte per cycle is added
// LSB first with the carry held in a register between bytes. The result is
// held with out_valid until the consumer takes it.
// Optional feature: define CSA_SEQ_SUB_EN to add the in_sub port (a - b).
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in idle)
//   in_a, in_b, in_cin   operands and carry-in to byte 0
//   in_sub               subtract request (CSA_SEQ_SUB_EN only)
//   out_valid/out_ready  result handshake
//   out_sum, out_cout    W-bit result and carry-out of the top byte
//   out_ovf              signed overflow
//   busy                 high whenever not idle
module csa8_wide_add_seq
  import csa8_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NBYTES*BYTE_W-1:0] in_a,
  input  logic [NBYTES*BYTE_W-1:0] in_b,
  input  logic                     in_cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NBYTES*BYTE_W-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int unsigned W     = NBYTES * BYTE_W;
  localparam int unsigned IDX_W = clog2(NBYTES);

  state_e             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       res_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [W-1:0]       eff_b;
  logic               eff_cin;
  logic [BYTE_W-1:0]  add_sum;
  logic               add_cout;
  logic               last_byte;
  logic               top_c7;

  // Effective operand B and initial carry as seen at accept.
  always_comb begin
    eff_b   = in_b;
    eff_cin = in_cin;
`ifdef CSA_SEQ_SUB_EN
    if (in_sub) begin
      eff_b   = ~in_b;
      eff_cin = 1'b1;
    end
`endif
  end

  carry_select_adder8 u_adder (
    .a    (a_q[BYTE_W-1:0]),
    .b    (b_q[BYTE_W-1:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));
  // Carry into bit 7 of the current slice, recovered without touching the adder.
  assign top_c7    = a_q[BYTE_W-1] ^ b_q[BYTE_W-1] ^ add_sum[BYTE_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= eff_b;
            carry_q    <= eff_cin;
            idx_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          // Operands shift down so byte idx is always at the bottom; the
          // result fills from the top so byte 0 lands at the bottom last.
          a_q     <= a_q >> BYTE_W;
          b_q     <= b_q >> BYTE_W;
          res_q   <= {add_sum, res_q[W-1:BYTE_W]};
          carry_q <= add_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_byte) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            cout_q      <= add_cout;
            ovf_q       <= top_c7 ^ add_cout;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_csa8_wide_add_seq.sv
// Self-checking bench for csa8_wide_add_seq (NBYTES = 4).
module tb_csa8_wide_add_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = NB * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csa8_wide_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CSA_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // Reference: {ovf, cout, sum} from plain W-bit arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + ((sub ? 1'b1 : cin) ? 33'd1 : 33'd0);
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Drive one request from idle and wait (bounded) for the result; lat counts
  // edges from the accept edge inclusive. Result is left pending in DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic co,
                       output logic ov, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'b1;
    in_sub   = ~sub;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s  = out_sum;
    co = out_cout;
    ov = out_ovf;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf, busy} !== {1'b1, 1'b0, 32'h0, 3'b000})
    begin
      bad++;
      $display("FAIL reset: got rdy=%b vld=%b sum=%h co=%b ov=%b busy=%b want 1 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000};
    logic [W-1:0] tb [5] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,
                             32'h8000_0000};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [5] = '{32'h0000_0003, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000,
                             32'h0000_0000};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tc[i], 1'b0, s, co, ov, lat);
      total++;
      if (lat !== NB + 1) begin
        bad++;
        $display("FAIL basic%0d_latency: got %0d edges want %0d", i, lat, NB + 1);
      end
      total++;
      if ({s, co, ov} !== {es[i], ec[i], eo[i]}) begin
        bad++;
        $display("FAIL basic%0d_result: got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                 i, s, co, ov, es[i], ec[i], eo[i]);
      end
      take_result();
    end
  endtask

  task automatic test_stall();
    int           g;
    logic [W-1:0] exp_s;
    exp_s = 32'h2345_6789;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h1111_1111;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({busy, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL stall_run_flags: got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    // Competing request mid-run must be ignored.
    in_valid = 1'b1;
    in_a     = 32'hFFFF_FFFF;
    in_b     = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      total++;
      if ({out_valid, out_sum, out_cout, out_ovf, in_ready, busy} !==
          {1'b1, exp_s, 2'b00, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold%0d: got vld=%b sum=%h co=%b ov=%b rdy=%b busy=%b want 1 %h 0 0 0 1",
                 i, out_valid, out_sum, out_cout, out_ovf, in_ready, busy, exp_s);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    take_result();
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL stall_release: got rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_ghost_op: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    int           seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'hFFFF_FFFF;
    in_b     = 32'h0000_0001;
    in_cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL areset_immediate: got vld=%b busy=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL areset_discard: got %0d cycles with vld/busy want 0", seen);
    end
    do_op(32'd5, 32'd7, 1'b0, 1'b0, s, co, ov, lat);
    total++;
    if ({s, co, ov} !== {32'h0000_000C, 2'b00}) begin
      bad++;
      $display("FAIL areset_next_op: got sum=%h co=%b ov=%b want 0000000c 0 0", s, co, ov);
    end
    take_result();
  endtask

`ifdef CSA_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    do_op(32'd5, 32'd7, 1'b0, 1'b1, s, co, ov, lat);
    total++;
    if ({s, co} !== {32'hFFFF_FFFE, 1'b0}) begin
      bad++;
      $display("FAIL sub_5_7: got sum=%h co=%b want fffffffe 0", s, co);
    end
    take_result();
    do_op(32'd7, 32'd5, 1'b0, 1'b1, s, co, ov, lat);
    total++;
    if ({s, co} !== {32'h0000_0002, 1'b1}) begin
      bad++;
      $display("FAIL sub_7_5: got sum=%h co=%b want 00000002 1", s, co);
    end
    take_result();
  endtask
`endif

  task automatic test_back_to_back();
    localparam int N     = 3000;
    localparam int LIMIT = 60000;
    logic [W+1:0] q[$];
    logic [W+1:0] exp_v;
    int           sent, got, cyc, in_flight_err;
    sent = 0;
    got  = 0;
    cyc  = 0;
    in_flight_err = 0;
    while (got < N && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (sent < N) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        in_b     = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom;
        in_cin   = 1'($urandom_range(0, 1));
`ifdef CSA_SEQ_SUB_EN
        in_sub   = 1'($urandom_range(0, 1));
`else
        in_sub   = 1'b0;
`endif
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_unexpected: got result %h with no request outstanding", out_sum);
        end else begin
          exp_v = q.pop_front();
          if ({out_ovf, out_cout, out_sum} !== exp_v) begin
            bad++;
            $display("FAIL b2b_op%0d: got ov=%b co=%b sum=%h want ov=%b co=%b sum=%h", got,
                     out_ovf, out_cout, out_sum, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
          end
        end
        got++;
      end
      if (q.size() > 1) in_flight_err++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (got != N) begin
      bad++;
      $display("FAIL b2b_timeout: got %0d results want %0d", got, N);
    end
    total++;
    if (in_flight_err != 0) begin
      bad++;
      $display("FAIL b2b_overlap: got %0d cycles with >1 accepted op want 0", in_flight_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_async_reset();
`ifdef CSA_SEQ_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
